pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Consumes the branch comparator flags (less/equal) in the RV32I single-cycle core.
- Decides whether the current control-flow instruction is taken, computes the target, and holds and updates the program counter.
- Drives the comparator's unsigned-select, detects misaligned targets (trap FSM), and keeps branch statistics counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and on restart
CNT_W, 32, width of the branch statistics counters

Ports:
clk_i  input  1  core clock, all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
stall_i  input  1  hold PC, trap state and counters this cycle
insn_vld_i  input  1  current instruction is valid; low = bubble, PC holds
branch_i  input  1  current instruction is B-type
jal_i  input  1  current instruction is JAL
jalr_i  input  1  current instruction is JALR
funct3_i  input  3  branch condition field
imm_i  input  32  sign-extended immediate
rs1_data_i  input  32  JALR base register
br_less_i  input  1  comparator less flag (signed or unsigned per br_unsigned_o)
br_equal_i  input  1  comparator equal flag
restart_i  input  1  leave TRAP, resume at RESET_PC
br_unsigned_o  output  1  unsigned-compare select to comparator
pc_o  output  32  current PC
pc_four_o  output  32  pc_o + 4, link value
taken_o  output  1  control transfer taken this cycle
trap_o  output  1  misaligned-target trap pending
trap_pc_o  output  32  PC of faulting instruction
branch_cnt_o  output  CNT_W  executed B-type instructions
taken_cnt_o  output  CNT_W  taken B-type instructions

Behaviour:
- Reset (rst_i=1 at edge): pc_o=RESET_PC, state=RUN, trap_o=0, trap_pc_o=0, both counters 0. Reset has priority over every other input.
- br_unsigned_o = funct3_i[1], combinational. It is independent of state.
- Branch condition, combinational:
  - 000 BEQ: eq
  - 001 BNE: ~eq
  - 100 BLT: less
  - 101 BGE: ~less
  - 110 BLTU: less
  - 111 BGEU: ~less
  - 010/011: not taken and not counted.
- Type priority when several are asserted: jalr_i > jal_i > branch_i.
- Targets:
  - JAL and branch: pc_o + imm_i.
  - JALR: (rs1_data_i + imm_i) & ~32'h1.
  - All arithmetic is modulo 2^32, with no overflow detection.
- taken_o, in RUN with insn_vld_i=1:
  - 1 for jal or jalr.
  - Equal to the condition result for a branch.
  - Otherwise 0.
  - Forced to 0 in TRAP. Combinational, same cycle as inputs.
- Misaligned detection: taken_o=1 and target[1:0]!=0.
- FSM, states RUN and TRAP.
  - RUN, edge with stall_i=0, insn_vld_i=1:
    - Misaligned: go to TRAP, trap_o<=1, trap_pc_o<=pc_o, PC unchanged.
    - Else pc <= taken ? target : pc+4.
    - Counters update on the same edge: branch_cnt +1 for a valid B-type with legal funct3; taken_cnt +1 if also taken. A misaligned taken branch counts in both counters.
  - RUN, stall_i=1 or insn_vld_i=0: PC and counters hold.
  - TRAP: PC, counters and trap_pc_o hold; taken_o=0. restart_i=1 at an edge: pc<=RESET_PC, trap_o<=0, state=RUN. trap_pc_o keeps its last value.
- Priority at each edge: rst_i > restart_i (in TRAP) > stall_i > normal update. restart_i in RUN is ignored.
- Counters wrap modulo 2^CNT_W.
- Latency: decision is combinational; PC update is 1 cycle.
- pc_four_o = pc_o + 4, combinational, wraps.

Decomposition:
- Shared package pc_branch_pkg holds:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - Enum pc_state_e {PC_RUN, PC_TRAP}.
- One combinational sub-module, br_cond_decode: inputs funct3, less, equal; outputs cond_taken, cond_legal.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with random inputs -> pc_o=0, trap_o=0, both counters 0, pc_four_o=4.
- BEQ/BNE at pc=0x10, imm=0x20, br_equal_i=1:
  - funct3=000 -> taken_o=1, next pc_o=0x30, branch_cnt=1, taken_cnt=1.
  - Then funct3=001, same flags -> pc_o=0x34, branch_cnt=2, taken_cnt=1.
- BLTU wrap: at pc=0x0, funct3=110, br_less_i=1, imm=0xFFFFFFF8 -> br_unsigned_o=1, taken_o=1, next pc_o=0xFFFFFFF8.
- JALR at pc=0x40:
  - rs1=0x101, imm=0x3 -> next pc_o=0x104.
  - Later rs1=0x105, imm=0x1 (target 0x106) -> trap_o=1, trap_pc_o=faulting PC, pc_o holds.
  - restart_i=1 -> pc_o=0x0, trap_o=0.
- Stall/bubble: taken BEQ with stall_i=1 for 3 cycles -> pc_o and counters unchanged. Release -> update on the next edge. insn_vld_i=0 -> pc_o holds.
- Simultaneous events:
  - In TRAP, rst_i=1 and restart_i=1 together -> full reset values, counters cleared.
  - jal_i and branch_i both 1 with a false condition -> JAL target taken, branch_cnt unchanged.

Source files
------------

// File: rtl/pc_branch_pkg.sv
// pc_branch_pkg: shared funct3 encodings and PC/trap state for the branch unit.
package pc_branch_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic {PC_RUN, PC_TRAP} pc_state_e;
endpackage

// File: rtl/pc_branch_if.sv
// pc_branch_if: decode/comparator-side signals of the PC and branch unit.
interface pc_branch_if #(parameter int CNT_W = 32);
  logic stall_i, insn_vld_i, branch_i, jal_i, jalr_i;
  logic [2:0] funct3_i;
  logic [31:0] imm_i, rs1_data_i;
  logic br_less_i, br_equal_i, restart_i;
  logic br_unsigned_o, taken_o, trap_o;
  logic [31:0] pc_o, pc_four_o, trap_pc_o;
  logic [CNT_W-1:0] branch_cnt_o, taken_cnt_o;
  modport master(
    output stall_i, insn_vld_i, branch_i, jal_i, jalr_i, funct3_i, imm_i, rs1_data_i,
           br_less_i, br_equal_i, restart_i,
    input  br_unsigned_o, taken_o, trap_o, pc_o, pc_four_o, trap_pc_o, branch_cnt_o, taken_cnt_o
  );
  modport slave(
    input  stall_i, insn_vld_i, branch_i, jal_i, jalr_i, funct3_i, imm_i, rs1_data_i,
           br_less_i, br_equal_i, restart_i,
    output br_unsigned_o, taken_o, trap_o, pc_o, pc_four_o, trap_pc_o, branch_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/br_cond_decode.sv
// br_cond_decode: evaluates the B-type condition from funct3 and comparator flags.
module br_cond_decode
  import pc_branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       less,
  input  logic       equal,
  output logic       cond_taken,
  output logic       cond_legal
);
  always_comb begin
    cond_legal = funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
    cond_taken = (funct3 == F3_BEQ) ? equal :
                 (funct3 == F3_BNE) ? ~equal :
                 (funct3 == F3_BLT || funct3 == F3_BLTU) ? less :
                 (funct3 == F3_BGE || funct3 == F3_BGEU) ? ~less : 1'b0;
  end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: branch decision, PC register, misaligned-target trap and branch statistics.
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  pc_branch_if.slave  bus
);
  pc_state_e state;
  logic [31:0] pc, trap_pc, target;
  logic trap, cond_taken, cond_legal, br_sel, taken, misaligned;
  logic [CNT_W-1:0] branch_cnt, taken_cnt;
  br_cond_decode u_dec (
    .funct3(bus.funct3_i), .less(bus.br_less_i), .equal(bus.br_equal_i),
    .cond_taken(cond_taken), .cond_legal(cond_legal)
  );
  always_comb begin
    br_sel     = bus.branch_i & ~bus.jal_i & ~bus.jalr_i;
    target     = bus.jalr_i ? (bus.rs1_data_i + bus.imm_i) & ~32'h1 : pc + bus.imm_i;
    taken      = (state == PC_RUN) && bus.insn_vld_i && (bus.jalr_i || bus.jal_i || (br_sel && cond_taken));
    misaligned = taken && (target[1:0] != 2'b00);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= PC_RUN;
      pc         <= RESET_PC;
      trap       <= 1'b0;
      trap_pc    <= 32'h0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (state == PC_TRAP) begin
      if (bus.restart_i) begin
        state <= PC_RUN;
        pc    <= RESET_PC;
        trap  <= 1'b0;
      end
    end else if (!bus.stall_i && bus.insn_vld_i) begin
      // a misaligned taken branch is still counted as executed and taken
      branch_cnt <= branch_cnt + CNT_W'(br_sel & cond_legal);
      taken_cnt  <= taken_cnt + CNT_W'(br_sel & cond_legal & taken);
      if (misaligned) begin
        state   <= PC_TRAP;
        trap    <= 1'b1;
        trap_pc <= pc;
      end else begin
        pc <= taken ? target : pc + 32'd4;
      end
    end
  end
  assign bus.br_unsigned_o = bus.funct3_i[1];
  assign bus.taken_o       = taken;
  assign bus.pc_o          = pc;
  assign bus.pc_four_o     = pc + 32'd4;
  assign bus.trap_o        = trap;
  assign bus.trap_pc_o     = trap_pc;
  assign bus.branch_cnt_o  = branch_cnt;
  assign bus.taken_cnt_o   = taken_cnt;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed checks of the PC/branch unit with hand-computed expectations.
module tb_pc_branch_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  pc_branch_if #(.CNT_W(32)) bus ();
  pc_branch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic insn(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                      input logic [31:0] imm, input logic [31:0] rs1, input logic less, input logic eq);
    bus.insn_vld_i = 1'b1;
    bus.branch_i = br; bus.jal_i = jal; bus.jalr_i = jalr; bus.funct3_i = f3;
    bus.imm_i = imm; bus.rs1_data_i = rs1; bus.br_less_i = less; bus.br_equal_i = eq;
    #1;
  endtask
  task automatic nop();
    insn(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic state_chk(input string tag, input logic [31:0] pc, input logic trap,
                           input logic [31:0] bc, input logic [31:0] tc);
    chk({tag, "_pc"}, bus.pc_o, pc);
    chk({tag, "_trap"}, {31'b0, bus.trap_o}, {31'b0, trap});
    chk({tag, "_bcnt"}, bus.branch_cnt_o, bc);
    chk({tag, "_tcnt"}, bus.taken_cnt_o, tc);
  endtask
  initial begin
    rst = 1'b1;
    bus.stall_i = 1'b0; bus.restart_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      insn(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      bus.stall_i = 1'($urandom); bus.restart_i = 1'($urandom);
      step();
    end
    rst = 1'b0; bus.stall_i = 1'b0; bus.restart_i = 1'b0;
    nop();
    state_chk("reset", 32'h0, 1'b0, 0, 0);
    chk("reset_trap_pc", bus.trap_pc_o, 32'h0);
    chk("reset_pc_four", bus.pc_four_o, 32'h4);
    bus.restart_i = 1'b1;
    step();
    bus.restart_i = 1'b0;
    chk("restart_in_run_ignored", bus.pc_o, 32'h4);
    for (int i = 0; i < 3; i++) step();
    chk("seq_pc", bus.pc_o, 32'h10);
    insn(1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 1'b0, 1'b1);
    chk("beq_taken", {31'b0, bus.taken_o}, 32'h1);
    chk("beq_unsigned", {31'b0, bus.br_unsigned_o}, 32'h0);
    step();
    state_chk("beq", 32'h30, 1'b0, 1, 1);
    insn(1'b1, 1'b0, 1'b0, 3'b001, 32'h20, 32'h0, 1'b0, 1'b1);
    chk("bne_taken", {31'b0, bus.taken_o}, 32'h0);
    step();
    state_chk("bne", 32'h34, 1'b0, 2, 1);
    insn(1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FFCC, 32'h0, 1'b0, 1'b0);
    step();
    state_chk("jal_back", 32'h0, 1'b0, 2, 1);
    insn(1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b0);
    chk("bltu_unsigned", {31'b0, bus.br_unsigned_o}, 32'h1);
    chk("bltu_taken", {31'b0, bus.taken_o}, 32'h1);
    step();
    state_chk("bltu", 32'hFFFF_FFF8, 1'b0, 3, 2);
    chk("pc_four_near_wrap", bus.pc_four_o, 32'hFFFF_FFFC);
    insn(1'b0, 1'b1, 1'b0, 3'b000, 32'h48, 32'h0, 1'b0, 1'b0);
    step();
    chk("jal_wrap", bus.pc_o, 32'h40);
    insn(1'b0, 1'b0, 1'b1, 3'b000, 32'h3, 32'h101, 1'b0, 1'b0);
    chk("jalr_taken", {31'b0, bus.taken_o}, 32'h1);
    step();
    chk("jalr_pc", bus.pc_o, 32'h104);
    insn(1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FF3C, 32'h0, 1'b0, 1'b0);
    step();
    chk("jal_to_40", bus.pc_o, 32'h40);
    insn(1'b0, 1'b0, 1'b1, 3'b000, 32'h1, 32'h105, 1'b0, 1'b0);
    step();
    state_chk("jalr_mis", 32'h40, 1'b1, 3, 2);
    chk("jalr_mis_trap_pc", bus.trap_pc_o, 32'h40);
    insn(1'b0, 1'b1, 1'b0, 3'b000, 32'h8, 32'h0, 1'b0, 1'b0);
    chk("trap_taken_low", {31'b0, bus.taken_o}, 32'h0);
    step();
    state_chk("trap_hold", 32'h40, 1'b1, 3, 2);
    nop();
    bus.restart_i = 1'b1;
    step();
    bus.restart_i = 1'b0;
    state_chk("restart", 32'h0, 1'b0, 3, 2);
    chk("restart_trap_pc_kept", bus.trap_pc_o, 32'h40);
    insn(1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 1'b0, 1'b1);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    state_chk("stall", 32'h0, 1'b0, 3, 2);
    bus.stall_i = 1'b0;
    step();
    state_chk("stall_release", 32'h20, 1'b0, 4, 3);
    bus.insn_vld_i = 1'b0;
    #1;
    chk("bubble_taken", {31'b0, bus.taken_o}, 32'h0);
    step();
    state_chk("bubble", 32'h20, 1'b0, 4, 3);
    insn(1'b1, 1'b0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b1);
    chk("illegal_f3_taken", {31'b0, bus.taken_o}, 32'h0);
    step();
    state_chk("illegal_f3", 32'h24, 1'b0, 4, 3);
    insn(1'b1, 1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 1'b0);
    chk("jal_br_taken", {31'b0, bus.taken_o}, 32'h1);
    step();
    state_chk("jal_br", 32'h34, 1'b0, 4, 3);
    insn(1'b1, 1'b0, 1'b0, 3'b000, 32'h2, 32'h0, 1'b0, 1'b1);
    step();
    state_chk("br_mis", 32'h34, 1'b1, 5, 4);
    chk("br_mis_trap_pc", bus.trap_pc_o, 32'h34);
    rst = 1'b1; bus.restart_i = 1'b1;
    step();
    rst = 1'b0; bus.restart_i = 1'b0;
    nop();
    state_chk("rst_restart", 32'h0, 1'b0, 0, 0);
    chk("rst_restart_trap_pc", bus.trap_pc_o, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
